// File: rtl/mcu_spi_bridge_if.sv
// mcu_spi_bridge_if: request/return bus between the SPI bridge and the PSRAM controller
interface mcu_spi_bridge_if #(
    parameter int ADDR_W = 23
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [7:0]        cmd_wdata;
    logic [7:0]        rd_data;
    logic              rd_valid;
    modport master (output cmd_valid, cmd_write, cmd_addr, cmd_wdata, input cmd_ready, rd_data, rd_valid);
    modport slave  (input cmd_valid, cmd_write, cmd_addr, cmd_wdata, output cmd_ready, rd_data, rd_valid);
endinterface

// File: rtl/mcu_spi_bridge.sv
// mcu_spi_bridge: SPI mode-0 slave turning MCU read/write frames into PSRAM requests.
// Defining MCU_SPI_STATUS_EN adds command 0x05 (read and clear the sticky error flags).
module mcu_spi_bridge #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 23
) (
    input  logic             SYS_CLK,
    input  logic             SYS_RSTn,
    input  logic             MCU_SPI_SCLK,
    input  logic             MCU_SPI_CS,
    input  logic             MCU_SPI_MOSI,
    output logic             MCU_SPI_MISO,
    output logic             overrun,
    output logic             underrun,
    mcu_spi_bridge_if.master psram
);
    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, WDATA, RDUMMY, RDATA, DROP
`ifdef MCU_SPI_STATUS_EN
        , STAT
`endif
    } state_t;

    state_t                 state, state_nx;
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_q, cs_q, sclk_s, cs_s, mosi_s;
    logic                   active, rise, fall, cs_fall, byte_done;
    logic                   boundary, addr_done, wr_done, pending, hs, rd_req;
    logic [2:0]             bit_cnt;
    logic [1:0]             byte_cnt, flush;
    logic                   armed, is_read, pref_vld, miso_q;
    logic [6:0]             shift_in;
    logic [7:0]             byte_in, miso_sr, pref;
    logic [ADDR_W-2:0]      addr_sr;
    logic [ADDR_W-1:0]      addr, addr_new, addr_inc;

    // Edge and byte-boundary decode; SCLK is only honoured inside a frame
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign active    = ~cs_s & (state != IDLE);
    assign rise      = active & sclk_s & ~sclk_q;
    assign fall      = active & ~sclk_s & sclk_q;
    assign cs_fall   = armed & cs_q & ~cs_s;
    assign byte_done = rise & (bit_cnt == 3'd7);
    assign byte_in   = {shift_in, mosi_s};
    assign addr_new  = {addr_sr, mosi_s};
    assign addr_inc  = addr + ADDR_W'(1);
    assign addr_done = byte_done & (state == ADDR) & (byte_cnt == 2'd2);
    assign boundary  = byte_done & (state == RDUMMY || state == RDATA);
    assign wr_done   = byte_done & (state == WDATA);
    assign hs        = psram.cmd_valid & psram.cmd_ready;
    assign pending   = psram.cmd_valid & ~psram.cmd_ready;
    assign rd_req    = ~pending & ((addr_done & is_read) | boundary);
    assign MCU_SPI_MISO = miso_q & ~MCU_SPI_CS;

    // Pin synchronisers plus one extra tap for edge detection
    always_ff @(posedge SYS_CLK or negedge SYS_RSTn)
        if (!SYS_RSTn) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], MCU_SPI_SCLK};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], MCU_SPI_CS};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MCU_SPI_MOSI};
            sclk_q    <= sclk_s;
            cs_q      <= cs_s;
        end

    // State register
    always_ff @(posedge SYS_CLK or negedge SYS_RSTn)
        if (!SYS_RSTn) state <= IDLE;
        else state <= state_nx;

    // Frame sequencing; CS high always forces IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cs_fall) state_nx = CMD;
            CMD:
                if (byte_done)
`ifdef MCU_SPI_STATUS_EN
                    state_nx = (byte_in == 8'h02 || byte_in == 8'h03) ? ADDR : (byte_in == 8'h05 ? STAT : DROP);
`else
                    state_nx = (byte_in == 8'h02 || byte_in == 8'h03) ? ADDR : DROP;
`endif
            ADDR:    if (addr_done) state_nx = is_read ? RDUMMY : WDATA;
            RDUMMY:  if (byte_done) state_nx = RDATA;
`ifdef MCU_SPI_STATUS_EN
            STAT:    if (byte_done) state_nx = DROP;
`endif
            default: ;
        endcase
        if (cs_s) state_nx = IDLE;
    end

    // Shifters, counters, request port and sticky flags; a frame only starts after CS was seen high post-reset
    always_ff @(posedge SYS_CLK or negedge SYS_RSTn)
        if (!SYS_RSTn) begin
            flush           <= '0;
            armed           <= 1'b0;
            bit_cnt         <= '0;
            byte_cnt        <= '0;
            shift_in        <= '0;
            addr_sr         <= '0;
            addr            <= '0;
            is_read         <= 1'b0;
            miso_sr         <= '0;
            miso_q          <= 1'b0;
            pref            <= '0;
            pref_vld        <= 1'b0;
            overrun         <= 1'b0;
            underrun        <= 1'b0;
            psram.cmd_valid <= 1'b0;
            psram.cmd_write <= 1'b0;
            psram.cmd_addr  <= '0;
            psram.cmd_wdata <= '0;
        end else begin
            if (flush != 2'd3) flush <= flush + 2'd1;
            armed <= armed | (cs_s & (flush == 2'd3));
            if (hs) psram.cmd_valid <= 1'b0;
            if (cs_s) begin
                bit_cnt  <= '0;
                byte_cnt <= '0;
                miso_sr  <= '0;
                miso_q   <= 1'b0;
            end
            if (rise) begin
                bit_cnt  <= bit_cnt + 3'd1;
                shift_in <= byte_in[6:0];
                addr_sr  <= addr_new[ADDR_W-2:0];
            end
            if (fall) begin
                miso_q  <= miso_sr[7];
                miso_sr <= {miso_sr[6:0], 1'b0};
            end
            if (byte_done && state == CMD) is_read <= byte_in == 8'h03;
            if (byte_done && state == ADDR) byte_cnt <= byte_cnt + 2'd1;
            if (addr_done) addr <= addr_new;
            if (state != RDUMMY && state != RDATA) pref_vld <= 1'b0;
            else if (psram.rd_valid) begin
                pref     <= psram.rd_data;
                pref_vld <= 1'b1;
            end
            if (boundary) begin
                miso_sr  <= pref_vld ? pref : 8'hFF;
                pref_vld <= 1'b0;
                addr     <= addr_inc;
                if (!pref_vld) underrun <= 1'b1;
            end
            if (rd_req) begin
                psram.cmd_valid <= 1'b1;
                psram.cmd_write <= 1'b0;
                psram.cmd_addr  <= addr_done ? addr_new : addr_inc;
            end
            if (wr_done) begin
                if (pending) overrun <= 1'b1;
                else begin
                    psram.cmd_valid <= 1'b1;
                    psram.cmd_write <= 1'b1;
                    psram.cmd_addr  <= addr;
                    psram.cmd_wdata <= byte_in;
                    addr            <= addr_inc;
                end
            end
`ifdef MCU_SPI_STATUS_EN
            if (byte_done && state == CMD && byte_in == 8'h05) miso_sr <= {6'b0, underrun, overrun};
            if (byte_done && state == STAT) begin
                overrun  <= 1'b0;
                underrun <= 1'b0;
            end
`endif
        end
endmodule
